// File: rtl/uart_cmd_sequencer.sv
// Host command sequencer: decodes UART command bytes, strobes the capture
// engine, holds the sample-clock divider and is sole master of the UART TX.
// Ports:
//   input_clk, reset_n        clock, async active-low reset
//   rx_data/rx_valid          received command/argument bytes
//   tx_data/tx_start/tx_busy  transmitter byte handshake
//   cap_reset/cap_arm         1-cycle capture-engine strobes
//   cap_done/cap_count        capture status and sample count
//   mem_addr/mem_rd_en/mem_rd_data  sample memory read port (1-cycle latency)
//   cfg_div                   sample-clock divider
//   busy                      high whenever the FSM is not idle
module uart_cmd_sequencer #(
    parameter int          SAMPLE_W    = 16,
    parameter int          ADDR_W      = 12,
    parameter logic [7:0]  ID_BYTE     = 8'h4C,
    parameter logic [15:0] DIV_DEFAULT = 16'd1
) (
    input  logic                input_clk,
    input  logic                reset_n,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic [7:0]          tx_data,
    output logic                tx_start,
    input  logic                tx_busy,
    output logic                cap_reset,
    output logic                cap_arm,
    input  logic                cap_done,
    input  logic [ADDR_W:0]     cap_count,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_rd_en,
    input  logic [SAMPLE_W-1:0] mem_rd_data,
    output logic [15:0]         cfg_div,
    output logic                busy
);

    localparam int BPS  = SAMPLE_W / 8;
    localparam int BI_W = (BPS > 1) ? $clog2(BPS) : 1;

    localparam logic [7:0] ACK   = 8'h06;
    localparam logic [7:0] NAK   = 8'h15;
    localparam logic [7:0] ABORT = 8'h18;
    localparam logic [7:0] HDR   = 8'hA5;

    localparam logic [ADDR_W:0]   CNT_ONE  = 1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [BI_W-1:0]   BI_ONE   = 1;
    localparam logic [BI_W-1:0]   BI_LAST  = BI_W'(BPS - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_STROBE, S_DIV_LO, S_DIV_HI, S_RD_REQ,
        S_RD_LAT, S_TX_LOAD, S_TX_WAIT_HI, S_TX_WAIT_LO
    } state_e;

    // Which byte of a response is in flight; decides what follows it.
    typedef enum logic [2:0] {
        PH_ONE, PH_HDR, PH_CNT_LO, PH_CNT_HI, PH_DATA
    } phase_e;

    state_e                state_q, state_d;
    phase_e                phase_q, phase_d;
    logic [7:0]            tx_q, tx_d;
    logic [15:0]           div_q, div_d;
    logic [7:0]            lo_q, lo_d;
    logic [ADDR_W:0]       n_q, n_d;
    logic [ADDR_W:0]       cnt_q, cnt_d;
    logic [ADDR_W:0]       cnt_nxt;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [SAMPLE_W-1:0]   sh_q, sh_d;
    logic [BI_W-1:0]       bidx_q, bidx_d;
    logic                  abort_q, abort_d;
    logic                  srst_q, srst_d;
    logic                  streaming;

    always_ff @(posedge input_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            phase_q <= PH_ONE;
            tx_q    <= '0;
            div_q   <= DIV_DEFAULT;
            lo_q    <= '0;
            n_q     <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            sh_q    <= '0;
            bidx_q  <= '0;
            abort_q <= 1'b0;
            srst_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            tx_q    <= tx_d;
            div_q   <= div_d;
            lo_q    <= lo_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            sh_q    <= sh_d;
            bidx_q  <= bidx_d;
            abort_q <= abort_d;
            srst_q  <= srst_d;
        end
    end

    assign cnt_nxt   = cnt_q + CNT_ONE;
    assign streaming = (phase_q != PH_ONE) &&
                       (state_q inside {S_RD_REQ, S_RD_LAT, S_TX_LOAD,
                                        S_TX_WAIT_HI, S_TX_WAIT_LO});

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        tx_d      = tx_q;
        div_d     = div_q;
        lo_d      = lo_q;
        n_d       = n_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        sh_d      = sh_q;
        bidx_d    = bidx_q;
        abort_d   = abort_q;
        srst_d    = srst_q;
        tx_start  = 1'b0;
        cap_reset = 1'b0;
        cap_arm   = 1'b0;
        mem_rd_en = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    phase_d = PH_ONE;
                    abort_d = 1'b0;
                    state_d = S_TX_LOAD;
                    tx_d    = NAK;
                    case (rx_data)
                        8'h00: begin
                            srst_d  = 1'b1;
                            state_d = S_STROBE;
                        end
                        8'h01: begin
                            srst_d  = 1'b0;
                            state_d = S_STROBE;
                        end
                        8'h02: tx_d = ID_BYTE;
                        8'h03: begin
                            if (cap_done) begin
                                n_d     = cap_count;
                                tx_d    = HDR;
                                phase_d = PH_HDR;
                            end
                        end
                        8'h04: state_d = S_DIV_LO;
                        default: ;
                    endcase
                end
            end
            S_STROBE: begin
                cap_reset = srst_q;
                cap_arm   = !srst_q;
                tx_d      = ACK;
                state_d   = S_TX_LOAD;
            end
            S_DIV_LO: begin
                if (rx_valid) begin
                    lo_d    = rx_data;
                    state_d = S_DIV_HI;
                end
            end
            S_DIV_HI: begin
                if (rx_valid) begin
                    div_d   = {rx_data, lo_q};
                    tx_d    = ACK;
                    state_d = S_TX_LOAD;
                end
            end
            S_RD_REQ: begin
                mem_rd_en = 1'b1;
                state_d   = S_RD_LAT;
            end
            S_RD_LAT: begin
                sh_d    = mem_rd_data;
                tx_d    = mem_rd_data[7:0];
                bidx_d  = '0;
                state_d = S_TX_LOAD;
            end
            S_TX_LOAD: begin
                // An abort seen before this byte started ends the stream here.
                if (abort_q) begin
                    state_d = S_IDLE;
                end else if (!tx_busy) begin
                    tx_start = 1'b1;
                    state_d  = S_TX_WAIT_HI;
                end
            end
            S_TX_WAIT_HI: begin
                if (tx_busy) begin
                    state_d = S_TX_WAIT_LO;
                end
            end
            S_TX_WAIT_LO: begin
                if (!tx_busy) begin
                    state_d = S_TX_LOAD;
                    if (abort_q || phase_q == PH_ONE) begin
                        state_d = S_IDLE;
                    end else begin
                        unique case (phase_q)
                            PH_HDR: begin
                                tx_d    = n_q[7:0];
                                phase_d = PH_CNT_LO;
                            end
                            PH_CNT_LO: begin
                                tx_d    = 8'(n_q >> 8);
                                phase_d = PH_CNT_HI;
                            end
                            PH_CNT_HI: begin
                                phase_d = PH_DATA;
                                addr_d  = '0;
                                cnt_d   = '0;
                                state_d = (n_q == '0) ? S_IDLE : S_RD_REQ;
                            end
                            default: begin
                                if (bidx_q == BI_LAST) begin
                                    cnt_d = cnt_nxt;
                                    if (cnt_nxt == n_q) begin
                                        state_d = S_IDLE;
                                    end else begin
                                        // Saturate so a full memory never wraps.
                                        if (addr_q != ADDR_MAX) begin
                                            addr_d = addr_q + ADDR_ONE;
                                        end
                                        state_d = S_RD_REQ;
                                    end
                                end else begin
                                    bidx_d = bidx_q + BI_ONE;
                                    sh_d   = sh_q >> 8;
                                    tx_d   = 8'(sh_q >> 8);
                                end
                            end
                        endcase
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (rx_valid && rx_data == ABORT && streaming) begin
            abort_d = 1'b1;
        end
    end

    assign tx_data  = tx_q;
    assign mem_addr = addr_q;
    assign cfg_div  = div_q;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Randomised scoreboard bench for uart_cmd_sequencer with a UART TX model,
// a sample memory model and a byte-level reference model of every command.
module tb_uart_cmd_sequencer;

    localparam int SAMPLE_W = 16;
    localparam int ADDR_W   = 12;
    localparam int BPS      = SAMPLE_W / 8;
    localparam int MEM_N    = 1 << ADDR_W;

    logic                input_clk;
    logic                reset_n;
    logic [7:0]          rx_data;
    logic                rx_valid;
    logic [7:0]          tx_data;
    logic                tx_start;
    logic                tx_busy;
    logic                cap_reset;
    logic                cap_arm;
    logic                cap_done;
    logic [ADDR_W:0]     cap_count;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_rd_en;
    logic [SAMPLE_W-1:0] mem_rd_data;
    logic [15:0]         cfg_div;
    logic                busy;

    uart_cmd_sequencer #(
        .SAMPLE_W(SAMPLE_W),
        .ADDR_W(ADDR_W),
        .ID_BYTE(8'h4C),
        .DIV_DEFAULT(16'd1)
    ) dut (
        .input_clk(input_clk),
        .reset_n(reset_n),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .tx_data(tx_data),
        .tx_start(tx_start),
        .tx_busy(tx_busy),
        .cap_reset(cap_reset),
        .cap_arm(cap_arm),
        .cap_done(cap_done),
        .cap_count(cap_count),
        .mem_addr(mem_addr),
        .mem_rd_en(mem_rd_en),
        .mem_rd_data(mem_rd_data),
        .cfg_div(cfg_div),
        .busy(busy)
    );

    initial input_clk = 1'b0;
    always #5 input_clk = ~input_clk;

    int checks = 0;
    int failures = 0;
    int starts = 0;
    int rd_cnt = 0;
    int arm_cnt = 0;
    int rst_cnt = 0;
    int stall_len = 0;

    logic [7:0]          expq[$];
    logic [SAMPLE_W-1:0] mem [0:MEM_N-1];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Sample memory: read data valid the cycle after mem_rd_en.
    always @(posedge input_clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    end

    // Transmitter model: accepts a start, goes busy a little later,
    // stays busy for a random (or stalled) length, abandons on reset.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge input_clk);
            if (reset_n && tx_start) begin
                automatic logic [7:0] b = tx_data;
                automatic int gap = $urandom_range(1, 3);
                automatic int len = (stall_len > 0) ? stall_len
                                                   : $urandom_range(2, 6);
                automatic bit ab = 1'b0;
                for (int i = 0; i < gap && !ab; i++) begin
                    @(negedge input_clk);
                    if (!reset_n) ab = 1'b1;
                end
                if (!ab) begin
                    tx_busy = 1'b1;
                    for (int i = 0; i < len && !ab; i++) begin
                        @(negedge input_clk);
                        if (!reset_n) ab = 1'b1;
                        else if (tx_data !== b) chk("tx_data_stable", tx_data, b);
                    end
                    tx_busy = 1'b0;
                end
            end
        end
    end

    // Monitor: scoreboard pop on every tx_start, start-spacing rule,
    // pulse counters for strobes and memory reads.
    initial begin
        automatic bit pend = 1'b0;
        automatic bit saw_hi = 1'b0;
        forever begin
            @(negedge input_clk);
            if (!reset_n) begin
                pend = 1'b0;
            end else begin
                if (mem_rd_en) rd_cnt++;
                if (cap_arm) arm_cnt++;
                if (cap_reset) rst_cnt++;
                if (pend) begin
                    if (!saw_hi && tx_busy) saw_hi = 1'b1;
                    else if (saw_hi && !tx_busy) pend = 1'b0;
                end
                if (tx_start) begin
                    starts++;
                    chk("start_spacing", {31'd0, pend}, 32'd0);
                    pend = 1'b1;
                    saw_hi = 1'b0;
                    if (expq.size() == 0) begin
                        chk("unexpected_tx_byte", tx_data, 32'hFFFF_FFFF);
                    end else begin
                        automatic logic [7:0] e = expq.pop_front();
                        chk("tx_byte", tx_data, e);
                    end
                end
            end
        end
    end

    // Reference model: expected response bytes for a command byte.
    task automatic model_cmd(input logic [7:0] c);
        int n;
        case (c)
            8'h00, 8'h01: expq.push_back(8'h06);
            8'h02: expq.push_back(8'h4C);
            8'h03: begin
                if (!cap_done) begin
                    expq.push_back(8'h15);
                end else begin
                    n = int'(cap_count);
                    expq.push_back(8'hA5);
                    expq.push_back(8'(n % 256));
                    expq.push_back(8'((n / 256) % 256));
                    for (int i = 0; i < n; i++)
                        for (int b = 0; b < BPS; b++)
                            expq.push_back(8'(mem[i] >> (8 * b)));
                end
            end
            default: expq.push_back(8'h15);
        endcase
    endtask

    task automatic send_rx(input logic [7:0] b);
        @(negedge input_clk);
        rx_data = b;
        rx_valid = 1'b1;
        @(negedge input_clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        while ((busy || tx_busy || expq.size() != 0) && n < maxc) begin
            @(negedge input_clk);
            n++;
        end
        chk("idle_timeout", {31'd0, n >= maxc}, 32'd0);
        repeat (3) @(negedge input_clk);
    endtask

    // Wait until at least k bytes of this response started and a byte
    // is mid-transmission; checked #1 after the edge for settled values.
    task automatic wait_mid(input int s0, input int k);
        int n = 0;
        @(negedge input_clk);
        #1;
        while (!((starts - s0) >= k && tx_busy) && n < 5000) begin
            @(negedge input_clk);
            #1;
            n++;
        end
        chk("mid_stream_timeout", {31'd0, n >= 5000}, 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, a0, r0, k, total;
        logic [15:0] div_exp;
        logic [7:0] c, lo, hi, j;

        rx_data = '0;
        rx_valid = 1'b0;
        cap_done = 1'b0;
        cap_count = '0;
        reset_n = 1'b0;
        for (int i = 0; i < MEM_N; i++) mem[i] = SAMPLE_W'($urandom);

        repeat (3) @(negedge input_clk);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_cap_reset", cap_reset, 0);
        chk("rst_cap_arm", cap_arm, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_rd_en", mem_rd_en, 0);
        chk("rst_cfg_div", cfg_div, 1);
        chk("rst_busy", busy, 0);
        reset_n = 1'b1;
        @(negedge input_clk);
        chk("post_rst_busy", busy, 0);

        // ARM: strobe exactly the cycle after rx_valid, then ACK.
        s0 = starts;
        a0 = arm_cnt;
        model_cmd(8'h01);
        send_rx(8'h01);
        chk("arm_pulse", cap_arm, 1);
        chk("arm_no_reset", cap_reset, 0);
        @(negedge input_clk);
        chk("arm_pulse_end", cap_arm, 0);
        wait_idle(200);
        chk("arm_count", arm_cnt - a0, 1);
        chk("arm_starts", starts - s0, 1);

        // RESET command.
        a0 = rst_cnt;
        model_cmd(8'h00);
        send_rx(8'h00);
        chk("rst_pulse", cap_reset, 1);
        @(negedge input_clk);
        chk("rst_pulse_end", cap_reset, 0);
        wait_idle(200);
        chk("rst_count", rst_cnt - a0, 1);

        // SET_DIV, then an incomplete SET_DIV that waits without timeout.
        expq.push_back(8'h06);
        send_rx(8'h04);
        send_rx(8'h34);
        send_rx(8'h12);
        chk("div_1234", cfg_div, 16'h1234);
        wait_idle(200);
        send_rx(8'h04);
        send_rx(8'hFF);
        repeat (20) @(negedge input_clk);
        chk("div_partial", cfg_div, 16'h1234);
        chk("div_partial_busy", busy, 1);
        expq.push_back(8'h06);
        send_rx(8'h56);
        chk("div_56ff", cfg_div, 16'h56FF);
        wait_idle(200);

        model_cmd(8'h02);
        send_rx(8'h02);
        wait_idle(200);

        // Three-sample dump.
        mem[0] = 16'hBEEF;
        mem[1] = 16'h0102;
        mem[2] = 16'hCAFE;
        cap_done = 1'b1;
        cap_count = 13'd3;
        r0 = rd_cnt;
        model_cmd(8'h03);
        send_rx(8'h03);
        wait_idle(1000);
        chk("dump3_reads", rd_cnt - r0, 3);

        // Empty capture: header and count only.
        cap_count = 13'd0;
        r0 = rd_cnt;
        model_cmd(8'h03);
        send_rx(8'h03);
        wait_idle(500);
        chk("dump0_reads", rd_cnt - r0, 0);

        // Not captured -> NAK; unknown -> NAK with a long transmitter stall.
        cap_done = 1'b0;
        model_cmd(8'h03);
        send_rx(8'h03);
        wait_idle(200);
        stall_len = 500;
        s0 = starts;
        model_cmd(8'h7E);
        send_rx(8'h7E);
        wait_idle(2000);
        chk("stall_starts", starts - s0, 1);
        stall_len = 0;

        // Randomised command mix.
        div_exp = cfg_div;
        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 6))
                0: c = 8'h00;
                1: c = 8'h01;
                2: c = 8'h02;
                3, 4: c = 8'h03;
                5: c = 8'h04;
                default: c = 8'($urandom_range(5, 255));
            endcase
            cap_done = 1'($urandom_range(0, 3) != 0);
            cap_count = 13'($urandom_range(0, 24));
            for (int i = 0; i < 32; i++) mem[i] = SAMPLE_W'($urandom);
            if (c == 8'h04) begin
                lo = 8'($urandom);
                hi = 8'($urandom);
                div_exp = {hi, lo};
                expq.push_back(8'h06);
                send_rx(8'h04);
                send_rx(lo);
                send_rx(hi);
                wait_idle(500);
                chk("rand_div", cfg_div, div_exp);
            end else begin
                r0 = rd_cnt;
                model_cmd(c);
                s0 = starts;
                send_rx(c);
                if (c == 8'h03 && cap_done && cap_count >= 3) begin
                    // A stray non-abort byte mid-stream must be ignored.
                    wait_mid(s0, 2);
                    j = 8'($urandom);
                    if (j == 8'h18) j = 8'h19;
                    send_rx(j);
                end
                wait_idle(5000);
                if (c == 8'h03 && cap_done)
                    chk("rand_reads", rd_cnt - r0, int'(cap_count));
            end
        end

        // Full-memory stream aborted mid-byte.
        for (int i = 0; i < MEM_N; i++) mem[i] = SAMPLE_W'($urandom);
        cap_done = 1'b1;
        cap_count = 13'd4096;
        model_cmd(8'h03);
        total = expq.size();
        chk("full_len", total, 3 + 4096 * BPS);
        s0 = starts;
        send_rx(8'h03);
        wait_mid(s0, 20);
        k = starts - s0;
        send_rx(8'h18);
        begin
            int n = 0;
            while ((busy || tx_busy) && n < 1000) begin
                @(negedge input_clk);
                n++;
            end
            chk("abort_timeout", {31'd0, n >= 1000}, 32'd0);
        end
        repeat (10) @(negedge input_clk);
        chk("abort_starts", starts - s0, k);
        chk("abort_left", expq.size(), total - k);
        chk("abort_busy", busy, 0);
        expq.delete();

        // Reset mid-byte abandons the stream.
        model_cmd(8'h03);
        s0 = starts;
        send_rx(8'h03);
        wait_mid(s0, 5);
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_tx_start", tx_start, 0);
        chk("midrst_tx_data", tx_data, 0);
        chk("midrst_cfg_div", cfg_div, 1);
        expq.delete();
        repeat (3) @(negedge input_clk);
        reset_n = 1'b1;
        repeat (10) @(negedge input_clk);
        chk("after_rst_busy", busy, 0);
        chk("after_rst_txbusy", tx_busy, 0);
        s0 = starts;
        model_cmd(8'h02);
        send_rx(8'h02);
        wait_idle(200);
        chk("after_rst_starts", starts - s0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
